qupls_decode_src_pipe: RTL

//  Pipelined, multi-lane source-register decoder for the Qupls decode stage.

---
 rtl/qupls_decode_src_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/qupls_decode_src_pipe.sv
// ---------------------------------------------------------------------------
// qupls_decode_src_pipe
//
// Pipelined multi-lane source-register decoder for the Qupls decode stage.
// Converts the raw architectural source fields of a decode group (LANES
// instructions x NSRC sources) into extended register numbers.
//
// Per source, the mapping is:
//   * an immediate source maps to register 0,
//   * a REGX-prefixed instruction ORs EXT_BIT into its raw fields,
//   * raw register SP_RAW (unextended) becomes the per-mode stack pointer
//     SP_BASE + om.
//
// A REGX prefix extends the next valid instruction. This holds even when
// that instruction is in a later group, because the carry is kept in `pend`.
//
// One registered stage with a valid/ready handshake.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   flush       drops the held group, the pending prefix and the sticky error
//   in_valid    a decode group is offered
//   in_ready    the stage can take the group this cycle
//   in_om       operating mode of the offered group
//   in_lane_v   lane holds an instruction
//   in_pfx      lane holds a REGX prefix
//   in_raw      raw source fields, lane-major then source-minor
//   in_imm      source is an immediate
//   out_valid   decoded group is valid
//   out_ready   consumer takes the decoded group
//   out_lane_v  decoded instruction valid (prefix lanes squashed)
//   out_reg     mapped source registers, same ordering as in_raw
//   out_ext     REGX extension was applied to the lane
//   pfx_err     sticky flag: a prefix was followed by another prefix
// ---------------------------------------------------------------------------
module qupls_decode_src_pipe #(
    parameter int LANES   = 4,
    parameter int NSRC    = 3,
    parameter int RAWW    = 6,
    parameter int AREGW   = 9,
    parameter int SP_RAW  = 63,
    parameter int SP_BASE = 65,
    parameter int EXT_BIT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_om,
    input  logic [LANES-1:0]             in_lane_v,
    input  logic [LANES-1:0]             in_pfx,
    input  logic [LANES*NSRC*RAWW-1:0]   in_raw,
    input  logic [LANES*NSRC-1:0]        in_imm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0]             out_lane_v,
    output logic [LANES*NSRC*AREGW-1:0]  out_reg,
    output logic [LANES-1:0]             out_ext,
    output logic                         pfx_err
);

    localparam logic [AREGW-1:0] EXT_MASK = AREGW'(EXT_BIT);
    localparam logic [AREGW-1:0] SP_MATCH = AREGW'(SP_RAW);
    localparam logic [AREGW-1:0] SP_START = AREGW'(SP_BASE);

    logic                        pend;
    logic                        load;

    logic [LANES-1:0]            dec_lane_v;
    logic [LANES-1:0]            dec_ext;
    logic [LANES*NSRC*AREGW-1:0] dec_reg;
    logic                        dec_err;
    logic                        dec_carry;
    logic [AREGW-1:0]            map_tmp;

    // The stage is free when it holds nothing or its group leaves this cycle.
    // Flush is not folded in here. Instead it blocks the load in the
    // register block below.
    always_comb begin
        in_ready = !out_valid || out_ready;
        load     = in_valid && in_ready;
    end

    // Prefix scan and source mapping for the offered group.
    //
    // The carry enters from `pend` and ripples through the lanes in order.
    // An invalid lane passes the carry through untouched.
    //
    // Squashed prefix lanes and invalid lanes produce all-zero register
    // fields, so rename never sees stale numbers in them.
    always_comb begin
        dec_lane_v = '0;
        dec_ext    = '0;
        dec_reg    = '0;
        dec_err    = 1'b0;
        dec_carry  = pend;
        map_tmp    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_lane_v[l] && in_pfx[l]) begin
                if (dec_carry)
                    dec_err = 1'b1;
                dec_carry = 1'b1;
            end else if (in_lane_v[l]) begin
                dec_lane_v[l] = 1'b1;
                dec_ext[l]    = dec_carry;
                for (int s = 0; s < NSRC; s++) begin
                    if (in_imm[l*NSRC+s]) begin
                        map_tmp = '0;
                    end else begin
                        map_tmp = {{(AREGW-RAWW){1'b0}}, in_raw[(l*NSRC+s)*RAWW +: RAWW]};
                        if (dec_carry)
                            map_tmp = map_tmp | EXT_MASK;
                    end
                    // Only an unextended r63 is the stack pointer.
                    // An extended 63 is a normal register.
                    if (map_tmp == SP_MATCH)
                        map_tmp = SP_START + AREGW'(in_om);
                    dec_reg[(l*NSRC+s)*AREGW +: AREGW] = map_tmp;
                end
                dec_carry = 1'b0;
            end
        end
    end

    // Output register and prefix carry.
    //
    // Priority order is reset, then flush, then load, then drain.
    //
    // `pend` only changes on a load, so a trailing prefix survives idle and
    // stalled cycles. It waits there for the next group.
    //
    // pfx_err is sticky and clears only on reset or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_lane_v <= '0;
            out_reg    <= '0;
            out_ext    <= '0;
            pfx_err    <= 1'b0;
            pend       <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_lane_v <= '0;
            pfx_err    <= 1'b0;
            pend       <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_lane_v <= dec_lane_v;
            out_reg    <= dec_reg;
            out_ext    <= dec_ext;
            pfx_err    <= pfx_err | dec_err;
            pend       <= dec_carry;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
